// File: rtl/versat_fifo_pkg.sv
// Shared definitions for the Versat width-converting FIFO controller.
// Holds the byte-step derivation, the occupancy-counter width and the
// helpers used for the elaboration-time parameter checks.
package versat_fifo_pkg;

  // One cycle's accepted operations.
  typedef struct packed {
    logic push;
    logic pop;
  } fifo_op_t;

  // Number of bytes moved by one access of a port that is `bits` wide.
  function automatic int byte_width(input int bits);
    return bits / 8;
  endfunction

  // The level counter must hold 0..2^addr_w inclusive, so it needs one extra bit.
  function automatic int level_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/versat_fifo_ptr.sv
// Byte pointer for the asymmetric FIFO.
// Advances by STEP bytes when en_i is high, wrapping modulo 2^ADDR_W.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset (pointer -> 0)
//   clear_i synchronous flush (pointer -> 0), overrides en_i
//   en_i    advance the pointer this cycle
//   ptr_o   current pointer value
module versat_fifo_ptr #(
  parameter int ADDR_W = 6,
  parameter int STEP   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] ptr_o
);

  // Truncation to ADDR_W bits gives the modulo-2^ADDR_W step; a step equal to
  // the whole depth correctly becomes 0.
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(STEP);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = ptr_q + INC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/versat_asym_fifo_ctrl.sv
// Controller that runs an external dual-port asymmetric RAM as a
// width-converting FIFO. Port A of the RAM is the push side (W_DATA_W bits),
// port B the pop side (R_DATA_W bits, 1-cycle registered read).
// Ports:
//   clk_i, rst_i, clear_i            clock, sync active-high reset, sync flush
//   w_en_i, w_data_i, full_o         push request / data / "push would not fit"
//   r_en_i, r_data_o, r_valid_o      pop request / data / valid pulse (1 cycle later)
//   empty_o, level_o                 fewer than RSTEP bytes stored / byte occupancy
//   overflow_o, underflow_o          sticky rejected-push / rejected-pop flags
//   ram_*A_o, ram_*B_o, ram_doutB_i  RAM port controls and port-B read data
module versat_asym_fifo_ctrl
  import versat_fifo_pkg::*;
#(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                w_en_i,
  input  logic [W_DATA_W-1:0] w_data_i,
  output logic                full_o,
  input  logic                r_en_i,
  output logic [R_DATA_W-1:0] r_data_o,
  output logic                r_valid_o,
  output logic                empty_o,
  output logic [ADDR_W:0]     level_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic [W_DATA_W-1:0] ram_dinA_o,
  output logic [ADDR_W-1:0]   ram_addrA_o,
  output logic                ram_enA_o,
  output logic                ram_weA_o,
  output logic [R_DATA_W-1:0] ram_dinB_o,
  output logic [ADDR_W-1:0]   ram_addrB_o,
  output logic                ram_enB_o,
  output logic                ram_weB_o,
  input  logic [R_DATA_W-1:0] ram_doutB_i
);

  localparam int WSTEP = byte_width(W_DATA_W);
  localparam int RSTEP = byte_width(R_DATA_W);
  localparam int LVL_W = level_width(ADDR_W);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int RATIO = max_int(W_DATA_W, R_DATA_W) / min_int(W_DATA_W, R_DATA_W);

  localparam logic [LVL_W-1:0] FULL_THR = LVL_W'(DEPTH - WSTEP);
  localparam logic [LVL_W-1:0] W_INC    = LVL_W'(WSTEP);
  localparam logic [LVL_W-1:0] R_DEC    = LVL_W'(RSTEP);

  // Parameter sanity checks at elaboration.
  if ((W_DATA_W % 8) != 0 || (R_DATA_W % 8) != 0) begin : g_bad_bytes
    $error("versat_asym_fifo_ctrl: data widths must be multiples of 8");
  end
  if (!is_pow2(RATIO)) begin : g_bad_ratio
    $error("versat_asym_fifo_ctrl: width ratio must be a power of 2");
  end
  if (max_int(WSTEP, RSTEP) > DEPTH) begin : g_bad_depth
    $error("versat_asym_fifo_ctrl: widest access exceeds RAM capacity");
  end

  fifo_op_t          op;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;

  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              r_valid_q, r_valid_d;

  // Flags come straight from the stored level, so pop eligibility never sees
  // bytes pushed in the same cycle.
  always_comb begin
    full_o  = (level_q > FULL_THR);
    empty_o = (level_q < R_DEC);
  end

  // Reset and clear both suppress any RAM access in their cycle.
  always_comb begin
    op.push = w_en_i & ~full_o  & ~clear_i & ~rst_i;
    op.pop  = r_en_i & ~empty_o & ~clear_i & ~rst_i;
  end

  always_comb begin
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      level_d     = level_q + (op.push ? W_INC : '0) - (op.pop ? R_DEC : '0);
      overflow_d  = overflow_q  | (w_en_i & full_o);
      underflow_d = underflow_q | (r_en_i & empty_o);
    end
    // A pop accepted just before a clear still returns its data.
    r_valid_d = op.pop;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      r_valid_q   <= 1'b0;
    end else begin
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      r_valid_q   <= r_valid_d;
    end
  end

  versat_fifo_ptr #(.ADDR_W(ADDR_W), .STEP(WSTEP)) u_wptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .en_i    (op.push),
    .ptr_o   (wptr)
  );

  versat_fifo_ptr #(.ADDR_W(ADDR_W), .STEP(RSTEP)) u_rptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .en_i    (op.pop),
    .ptr_o   (rptr)
  );

  always_comb begin
    ram_enA_o   = op.push;
    ram_weA_o   = op.push;
    ram_addrA_o = wptr;
    ram_dinA_o  = w_data_i;
    ram_enB_o   = op.pop;
    ram_weB_o   = 1'b0;
    ram_addrB_o = rptr;
    ram_dinB_o  = '0;
  end

  // Data is forwarded only in the valid cycle so the output reads 0 otherwise.
  assign r_data_o    = r_valid_q ? ram_doutB_i : '0;
  assign r_valid_o   = r_valid_q;
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule
